uart_regif: RTL
===============

// Module: uart_regif
// PURPOSE
//  UART register file on the memory-side port of the APB slave wrapper: consumes mem_req/addr/we/wdata/wstrb,
//  returns mem_rdata/mem_error. Holds control/config registers plus TX and RX byte FIFOs that feed and drain
//  the UART serialiser/deserialiser. mem_addr_i is already base-relative (local offset).
// PARAMETERS
//  ADDR_W       32   local address width
//  DATA_W       64   register/data width; power of 2, >=32
//  FIFO_DEPTH   16   entries per TX/RX FIFO; power of 2, >=2
//  DEF_CLK_DIV  868  reset value of CLK_DIV (100 MHz / 115200)
// PORTS
//  clk_i        in   1         clock, all state on rising edge
//  arst_i       in   1         asynchronous, active-high reset
//  mem_req_i    in   1         access strobe; one access per cycle it is high
//  mem_addr_i   in   ADDR_W    local byte address
//  mem_we_i     in   1         1=write, 0=read
//  mem_wdata_i  in   DATA_W    write data
//  mem_wstrb_i  in   DATA_W/8  byte write strobes
//  mem_rdata_o  out  DATA_W    read data, combinational from current request
//  mem_error_o  out  1         access error, combinational, valid while mem_req_i=1
//  tx_data_o    out  8         TX FIFO head byte
//  tx_valid_o   out  1         TX FIFO non-empty and CTRL.tx_en
//  tx_ready_i   in   1         serialiser accepts head on tx_valid_o&tx_ready_i
//  rx_data_i    in   8         received byte
//  rx_valid_i   in   1         one-cycle pulse: push rx_data_i (no backpressure)
//  tx_en_o      out  1         CTRL.tx_en
//  rx_en_o      out  1         CTRL.rx_en
//  clk_div_o    out  32        CLK_DIV register
// BEHAVIOUR
//  Map (word = DATA_W/8 bytes; offset not word-aligned or >0x20 -> error, no side effect, rdata 0):
//   0x00 CTRL  RW  [0]tx_en [1]rx_en [2]tx_flush [3]rx_flush (flush bits self-clear, read 0)
//   0x08 CLK_DIV RW [31:0]; write of 0 ignored and errors
//   0x10 STATUS RO except [0] W1C: [0]rx_ovf [1]tx_full [2]tx_empty [3]rx_full [4]rx_empty
//        [15:8]tx_count [23:16]rx_count (count width $clog2(FIFO_DEPTH)+1, zero-extended)
//   0x18 TX_DATA WO: wdata[7:0] pushed if wstrb[0]; read -> error
//   0x20 RX_DATA RO: read returns {0,head} and pops at the clock edge; write -> error
//  Writes honour wstrb per byte; unimplemented bits read 0. All register updates at edge of mem_req_i cycle.
//  Reset: CTRL=0, CLK_DIV=DEF_CLK_DIV, rx_ovf=0, both FIFOs empty; tx_valid_o=0, tx_en_o=0, rx_en_o=0,
//   tx_data_o=0, clk_div_o=DEF_CLK_DIV. Reset mid-operation discards all FIFO contents immediately.
//  mem_rdata_o=0 whenever mem_req_i=0, mem_we_i=1 or mem_error_o=1.
//  TX FIFO: push on valid TX_DATA write; push when full -> mem_error_o=1, byte dropped. Pop on
//   tx_valid_o&tx_ready_i. Same-cycle push+pop (incl. when full) both succeed, count unchanged.
//   tx_en=0 holds tx_valid_o low; pushes still accepted.
//  RX FIFO: push on rx_valid_i&rx_en; rx_valid_i while rx_en=0 ignored. Push when full -> byte dropped,
//   rx_ovf set (sticky until W1C). Same-cycle pop of full FIFO and push -> both succeed, no ovf.
//   RX_DATA read when empty -> mem_error_o=1, rdata 0, no pop.
//  Flush: CTRL write with flush bit clears FIFO pointers/count at that edge; overrides same-cycle
//   push or pop on that FIFO. Pointers wrap modulo FIFO_DEPTH; full = count==FIFO_DEPTH.
//  Latency: TX_DATA write -> tx_valid_o high next cycle (if tx_en). rx_valid_i -> readable next cycle.
//  W1C of rx_ovf and new overflow in same cycle -> rx_ovf stays 1.
// TESTING
//  T1 reset: read 0x08 -> 868; 0x10 -> tx_empty=1,rx_empty=1,counts 0; tx_valid_o=0.
//  T2 CTRL=0x1, write 0x18 bytes 0x41,0x42, tx_ready_i=1 -> tx_data_o 0x41 then 0x42, tx_empty after.
//  T3 tx_en=0, 17 writes to 0x18 -> first 16 ok, 17th mem_error_o=1, STATUS tx_full=1, tx_count=16.
//  T4 rx_en=1, 17 rx_valid_i pulses 0x00..0x10 -> rx_ovf=1; 16 reads of 0x20 return 0x00..0x0F; 17th errors.
//  T5 rx full + same-cycle RX_DATA read and rx_valid_i -> no ovf, count stays 16; W1C 0x10 bit0 clears ovf.
//  T6 read 0x04 (misaligned), read 0x18, write 0x20, write CLK_DIV=0 -> mem_error_o=1, no state change.

Source files
------------

// File: rtl/uart_regif.sv
// uart_regif: UART CSRs and TX/RX byte FIFOs behind the mem_* port; tx_* feeds the serialiser, rx_* comes from the deserialiser, tx_en_o/rx_en_o/clk_div_o expose config
module uart_regif #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEF_CLK_DIV = 868
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                mem_req_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic                mem_we_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_error_o,
  output logic [7:0]          tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  output logic                tx_en_o,
  output logic                rx_en_o,
  output logic [31:0]         clk_div_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  logic tx_en, rx_en, rx_ovf;
  logic [31:0] clk_div, div_new;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic sel_ctrl, sel_div, sel_stat, sel_tx, sel_rx, wr, rd, err, ok_wr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_pop, tx_push, rx_pop, rx_push, rx_req, ovf_set;
  logic ctrl_wr, tx_flush, rx_flush, w1c;
  logic [DATA_W-1:0] status;
  logic unused_ok;
  assign sel_ctrl = mem_addr_i == ADDR_W'(8'h00);
  assign sel_div  = mem_addr_i == ADDR_W'(8'h08);
  assign sel_stat = mem_addr_i == ADDR_W'(8'h10);
  assign sel_tx   = mem_addr_i == ADDR_W'(8'h18);
  assign sel_rx   = mem_addr_i == ADDR_W'(8'h20);
  assign wr = mem_req_i & mem_we_i;
  assign rd = mem_req_i & ~mem_we_i;
  assign tx_full  = tx_cnt == FULL;
  assign tx_empty = tx_cnt == '0;
  assign rx_full  = rx_cnt == FULL;
  assign rx_empty = rx_cnt == '0;
  assign tx_valid_o = tx_en & ~tx_empty;
  assign tx_pop = tx_valid_o & tx_ready_i;
  always_comb begin
    div_new = clk_div;
    for (int i = 0; i < 4; i++)
      if (mem_wstrb_i[i]) div_new[8*i +: 8] = mem_wdata_i[8*i +: 8];
  end
  // a full TX FIFO still accepts a push when the serialiser drains the head in the same cycle
  assign err = mem_req_i & (~(sel_ctrl | sel_div | sel_stat | sel_tx | sel_rx) |
                            (rd & sel_tx) | (wr & sel_rx) | (wr & sel_div & (div_new == '0)) |
                            (wr & sel_tx & mem_wstrb_i[0] & tx_full & ~tx_pop) |
                            (rd & sel_rx & rx_empty));
  assign ok_wr    = wr & ~err;
  assign ctrl_wr  = ok_wr & sel_ctrl & mem_wstrb_i[0];
  assign tx_flush = ctrl_wr & mem_wdata_i[2];
  assign rx_flush = ctrl_wr & mem_wdata_i[3];
  assign w1c      = ok_wr & sel_stat & mem_wstrb_i[0] & mem_wdata_i[0];
  assign tx_push  = ok_wr & sel_tx & mem_wstrb_i[0];
  assign rx_pop   = rd & sel_rx & ~err;
  assign rx_req   = rx_valid_i & rx_en;
  assign rx_push  = rx_req & (~rx_full | rx_pop);
  assign ovf_set  = rx_req & rx_full & ~rx_pop & ~rx_flush;
  always_comb begin
    status = '0;
    status[0] = rx_ovf;
    status[1] = tx_full;
    status[2] = tx_empty;
    status[3] = rx_full;
    status[4] = rx_empty;
    status[8 +: CW] = tx_cnt;
    status[16 +: CW] = rx_cnt;
  end
  assign mem_rdata_o = (~rd | err) ? '0 :
                       sel_ctrl ? DATA_W'({rx_en, tx_en}) :
                       sel_div  ? DATA_W'(clk_div) :
                       sel_stat ? status : DATA_W'(rx_mem[rx_rp]);
  assign mem_error_o = err;
  assign tx_data_o = tx_empty ? '0 : tx_mem[tx_rp];
  assign tx_en_o = tx_en;
  assign rx_en_o = rx_en;
  assign clk_div_o = clk_div;
  assign unused_ok = ^{mem_wdata_i, mem_wstrb_i};
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tx_en   <= 1'b0;
      rx_en   <= 1'b0;
      clk_div <= 32'(DEF_CLK_DIV);
      rx_ovf  <= 1'b0;
      tx_wp   <= '0;
      tx_rp   <= '0;
      tx_cnt  <= '0;
      rx_wp   <= '0;
      rx_rp   <= '0;
      rx_cnt  <= '0;
    end else begin
      if (ctrl_wr) begin
        tx_en <= mem_wdata_i[0];
        rx_en <= mem_wdata_i[1];
      end
      if (ok_wr & sel_div) clk_div <= div_new;
      rx_ovf <= ovf_set | (rx_ovf & ~w1c);
      tx_wp  <= tx_flush ? '0 : tx_wp + PW'(tx_push);
      tx_rp  <= tx_flush ? '0 : tx_rp + PW'(tx_pop);
      tx_cnt <= tx_flush ? '0 : tx_cnt + CW'(tx_push) - CW'(tx_pop);
      rx_wp  <= rx_flush ? '0 : rx_wp + PW'(rx_push);
      rx_rp  <= rx_flush ? '0 : rx_rp + PW'(rx_pop);
      rx_cnt <= rx_flush ? '0 : rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp] <= mem_wdata_i[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_data_i;
  end
endmodule
